// File: rtl/vout_mem_pkg.sv
// Shared constants, dump FSM state type and lane range helper for vout_mem.
package vout_mem_pkg;

    localparam int unsigned PIXEL_W = 8;
    localparam int unsigned LANES   = 4;
    localparam int unsigned BASE    = 90302;
    localparam int unsigned DEPTH   = 90000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        PRESENT = 2'd2,
        DONE    = 2'd3
    } dump_state_t;

    function automatic logic lane_in_range(input logic [31:0] off,
                                           input int unsigned i,
                                           input int unsigned depth = DEPTH);
        return (off + 32'(i)) < 32'(depth);
    endfunction

endpackage

// File: rtl/vout_mem_dump_fsm.sv
// Dump sequencer: walks element offsets 0..LAST over a valid/ready handshake,
// requesting one synchronous array read per element.
module vout_mem_dump_fsm
    import vout_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = 24,
    parameter int unsigned LAST   = 89999
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dump_start,
    input  logic              dump_ready,
    output logic              dump_valid,
    output logic [ADDR_W-1:0] dump_addr,
    output logic              dump_busy,
    output logic              dump_done,
    output logic              mem_re
);

    dump_state_t       state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        case (state_q)
            IDLE: begin
                if (dump_start) begin
                    addr_d  = '0;
                    state_d = FETCH;
                end
            end
            FETCH:   state_d = PRESENT;
            PRESENT: begin
                if (dump_ready) begin
                    if (addr_q == ADDR_W'(LAST)) begin
                        state_d = DONE;
                    end else begin
                        addr_d  = addr_q + ADDR_W'(1);
                        state_d = FETCH;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    assign dump_valid = (state_q == PRESENT);
    assign dump_busy  = (state_q != IDLE);
    assign dump_done  = (state_q == DONE);
    assign mem_re     = (state_q == FETCH);
    assign dump_addr  = addr_q;

endmodule

// File: rtl/vout_mem.sv
// Output-image pixel memory with LANES-wide core port and streaming dump port.
// Optional macro VOUT_MEM_OOB_CNT_EN enables the out-of-window write counter.
module vout_mem
    import vout_mem_pkg::*;
#(
    parameter int unsigned ADDR_W  = 24,
    parameter int unsigned PIXEL_W = vout_mem_pkg::PIXEL_W,
    parameter int unsigned LANES   = vout_mem_pkg::LANES,
    parameter int unsigned DEPTH   = vout_mem_pkg::DEPTH,
    parameter int unsigned BASE    = vout_mem_pkg::BASE
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we,
    input  logic                     re,
    input  logic [ADDR_W-1:0]        a,
    input  logic [LANES*PIXEL_W-1:0] wd,
    input  logic [LANES-1:0]         lane_mask,
    output logic [LANES*PIXEL_W-1:0] rd,
    output logic                     rd_valid,
    input  logic                     dump_start,
    input  logic                     dump_ready,
    output logic                     dump_valid,
    output logic [PIXEL_W-1:0]       dump_data,
    output logic [ADDR_W-1:0]        dump_addr,
    output logic                     dump_busy,
    output logic                     dump_done,
    output logic [15:0]              oob_count
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PIXEL_W-1:0]       mem [DEPTH];
    logic [31:0]              a_ext;
    logic                     hit;
    logic [ADDR_W-1:0]        off;
    logic [LANES-1:0]         lane_ok;
    logic [IDX_W-1:0]         lane_idx [LANES];
    logic                     wr_en;
    logic                     dump_re;
    logic [LANES*PIXEL_W-1:0] rd_q, rd_d;
    logic                     rd_valid_q;
    logic [PIXEL_W-1:0]       dump_data_q, dump_data_d;

    assign a_ext = 32'(a);
    assign hit   = (a_ext >= 32'(BASE)) && (a_ext < 32'(BASE + DEPTH));
    assign off   = a - ADDR_W'(BASE);
    assign wr_en = we && hit && !dump_busy;

    always_comb begin
        lane_ok = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            lane_ok[i]  = lane_in_range(32'(off), i, DEPTH);
            lane_idx[i] = IDX_W'(32'(off) + 32'(i));
        end
    end

    // Contents deliberately have no reset so the image survives rst_n.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                if (lane_mask[i] && lane_ok[i]) begin
                    mem[lane_idx[i]] <= wd[i*PIXEL_W +: PIXEL_W];
                end
            end
        end
    end

    // Read samples pre-write contents, giving read-first on same-cycle overlap.
    always_comb begin
        rd_d = rd_q;
        if (re) begin
            rd_d = '0;
            for (int unsigned i = 0; i < LANES; i++) begin
                if (hit && !dump_busy && lane_ok[i]) begin
                    rd_d[i*PIXEL_W +: PIXEL_W] = mem[lane_idx[i]];
                end
            end
        end
    end

    always_comb begin
        dump_data_d = dump_data_q;
        if (dump_re) begin
            dump_data_d = mem[dump_addr[IDX_W-1:0]];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q        <= '0;
            rd_valid_q  <= 1'b0;
            dump_data_q <= '0;
        end else begin
            rd_q        <= rd_d;
            rd_valid_q  <= re;
            dump_data_q <= dump_data_d;
        end
    end

    assign rd        = rd_q;
    assign rd_valid  = rd_valid_q;
    assign dump_data = dump_data_q;

    vout_mem_dump_fsm #(
        .ADDR_W (ADDR_W),
        .LAST   (DEPTH - 1)
    ) u_dump_fsm (
        .clk        (clk),
        .rst_n      (rst_n),
        .dump_start (dump_start),
        .dump_ready (dump_ready),
        .dump_valid (dump_valid),
        .dump_addr  (dump_addr),
        .dump_busy  (dump_busy),
        .dump_done  (dump_done),
        .mem_re     (dump_re)
    );

`ifdef VOUT_MEM_OOB_CNT_EN
    logic [15:0] oob_q, oob_d;
    logic        oob_evt;

    always_comb begin
        oob_evt = 1'b0;
        if (we) begin
            oob_evt = !hit || dump_busy || |(lane_mask & ~lane_ok);
        end
        oob_d = oob_q;
        if (oob_evt && (oob_q != '1)) begin
            oob_d = oob_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oob_q <= '0;
        end else begin
            oob_q <= oob_d;
        end
    end

    assign oob_count = oob_q;
`else
    assign oob_count = '0;
`endif

endmodule
